// File: rtl/ir_tx_scheduler.sv
// Round-robin scheduler that time-shares one IR emitter between NUM_REQ requesters.
// Each grant is one fixed-length carrier burst followed by a mandatory quiet gap.
module ir_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned BURST_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES   = 50000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic                   CLK100MHZ,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_freq,
  input  logic                   abort,
  output logic                   emit_enable,
  output logic [1:0]             emit_freq_sel,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     aborted,
  output logic                   busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [PTR_W-1:0]   rr_ptr, rr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [1:0]         freq_d;
  logic               en_d, busy_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [1:0]         win_code;
  int unsigned        j;

  // Eligibility and first-eligible search upward from rr_ptr with wrap
  always_comb begin
    eligible  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_code  = 2'b00;
    j         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && (req_freq[2*i +: 2] != 2'b00);
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (k + 32'(rr_ptr)) % NUM_REQ;
      if (!win_found && eligible[j]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
        win_code  = req_freq[2*j +: 2];
      end
    end
  end

  // Next-state and next registered outputs
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rr_d    = rr_ptr;
    grant_d = grant;
    freq_d  = emit_freq_sel;
    en_d    = emit_enable;
    busy_d  = busy;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = BURST;
          cnt_d   = '0;
          rr_d    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          grant_d = NUM_REQ'(1) << win_idx;
          freq_d  = win_code;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      BURST: begin
        if (abort || cnt == BURST_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          grant_d = '0;
          freq_d  = 2'b00;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
        freq_d  = 2'b00;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      grant         <= '0;
      emit_freq_sel <= 2'b00;
      emit_enable   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rr_ptr        <= rr_d;
      grant         <= grant_d;
      emit_freq_sel <= freq_d;
      emit_enable   <= en_d;
      busy          <= busy_d;
    end
  end

  // Status pulses must coincide with abort, so they are decoded from the owner register;
  // an abort on the final burst cycle suppresses done.
  assign done    = (state == BURST && cnt == BURST_LAST && !abort) ? grant : '0;
  assign aborted = (state == BURST && abort) ? grant : '0;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler with NUM_REQ=3, BURST_CYCLES=8, GAP_CYCLES=4.
module tb_ir_tx_scheduler;

  localparam int unsigned N = 3;
  localparam int unsigned B = 8;
  localparam int unsigned G = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_freq;
  logic           abort;
  logic           emit_enable;
  logic [1:0]     emit_freq_sel;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [N-1:0]   aborted;
  logic           busy;

  int vectors;
  int miscompares;

  ir_tx_scheduler #(
    .NUM_REQ(N), .BURST_CYCLES(B), .GAP_CYCLES(G), .CNT_W(8)
  ) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .req(req), .req_freq(req_freq), .abort(abort),
    .emit_enable(emit_enable), .emit_freq_sel(emit_freq_sel), .grant(grant),
    .done(done), .aborted(aborted), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {enable, freq_sel, grant, done, aborted, busy}
  function automatic logic [12:0] pk(input logic en, input logic [1:0] fs, input logic [2:0] g,
                                      input logic [2:0] d, input logic [2:0] a, input logic b);
    return {en, fs, g, d, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_freq = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0; req = 3'b111; req_freq = 6'b010101; abort = 1'b0;
    #1;
    obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", obs, 13'd0);
    end
    do_reset();
    obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", obs, 13'd0);
    end
  endtask

  // One burst, code 10; req_freq wiggles mid-burst and must be ignored
  task automatic test_single_burst();
    logic [12:0] obs, exp;
    do_reset();
    req = 3'b001; req_freq = 6'b000010;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 3) req_freq = 6'b000001;
      if (c == 9) req = 3'b000;
      #1;
      if (c <= 8) exp = pk(1'b1, 2'b10, 3'b001, (c == 8) ? 3'b001 : 3'b000, 3'b000, 1'b1);
      else if (c <= 12) exp = pk(1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 1'b1);
      else exp = 13'd0;
      obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_burst cycle %0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  // All three continuously eligible: grants rotate 001,010,100,001 every B+G+1 cycles
  task automatic test_rotation();
    logic [12:0] obs, exp;
    logic [2:0]  g;
    int p, k;
    do_reset();
    req = 3'b111; req_freq = 6'b010101;
    for (int c = 1; c <= 52; c++) begin
      tick();
      #1;
      p = (c - 1) % 13;
      k = (c - 1) / 13;
      g = 3'b001 << (k % 3);
      if (p < 8) exp = pk(1'b1, 2'b01, g, (p == 7) ? g : 3'b000, 3'b000, 1'b1);
      else if (p < 12) exp = pk(1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 1'b1);
      else exp = 13'd0;
      obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rotation cycle %0d: got %b want %b", c, obs, exp);
      end
    end
    req = 3'b000;
  endtask

  // Requester 0 asks with invalid code 00; only requester 1 (code 11) is served
  task automatic test_invalid_code();
    logic [12:0] obs, exp;
    do_reset();
    req = 3'b011; req_freq = 6'b001100;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 9) req = 3'b001;
      #1;
      if (c <= 8) exp = pk(1'b1, 2'b11, 3'b010, (c == 8) ? 3'b010 : 3'b000, 3'b000, 1'b1);
      else if (c <= 12) exp = pk(1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 1'b1);
      else exp = 13'd0;
      obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL invalid_code cycle %0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  // Only code-00 requesters plus a stray abort in IDLE: nothing happens
  task automatic test_idle_ignore();
    logic [12:0] obs;
    do_reset();
    req = 3'b111; req_freq = 6'b000000; abort = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      #1;
      obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
      vectors++;
      if (obs !== 13'd0) begin
        miscompares++;
        $display("FAIL idle_ignore cycle %0d: got %b want %b", c, obs, 13'd0);
      end
    end
    abort = 1'b0;
  endtask

  // Abort on burst cycle ab_c; burst then gap of G cycles, idle after
  task automatic test_abort(input int ab_c, input logic [2:0] r, input logic [5:0] f,
                            input logic [1:0] code);
    logic [12:0] obs, exp;
    do_reset();
    req = r; req_freq = f;
    for (int c = 1; c <= ab_c + G + 1; c++) begin
      tick();
      abort = (c == ab_c);
      if (c == ab_c + 1) req = 3'b000;
      #1;
      if (c < ab_c) exp = pk(1'b1, code, r, 3'b000, 3'b000, 1'b1);
      else if (c == ab_c) exp = pk(1'b1, code, r, 3'b000, r, 1'b1);
      else if (c <= ab_c + G) exp = pk(1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 1'b1);
      else exp = 13'd0;
      obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL abort_at_%0d cycle %0d: got %b want %b", ab_c, c, obs, exp);
      end
    end
    abort = 1'b0;
  endtask

  // Async reset at burst cycle 4, then arbitration restarts at requester 0
  task automatic test_reset_mid_burst();
    logic [12:0] obs, exp;
    do_reset();
    req = 3'b001; req_freq = 6'b000010;
    for (int c = 1; c <= 4; c++) tick();
    rst_n = 1'b0;
    #1;
    obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid_burst: got %b want %b", obs, 13'd0);
    end
    tick();
    tick();
    rst_n = 1'b1; req = 3'b011; req_freq = 6'b000101;
    tick();
    #1;
    exp = pk(1'b1, 2'b01, 3'b001, 3'b000, 3'b000, 1'b1);
    obs = {emit_enable, emit_freq_sel, grant, done, aborted, busy};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_restart: got %b want %b", obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; req = '0; req_freq = '0; abort = 1'b0;
    test_reset();
    test_single_burst();
    test_rotation();
    test_invalid_code();
    test_idle_ignore();
    test_abort(3, 3'b001, 6'b000001, 2'b01);
    test_abort(8, 3'b100, 6'b110000, 2'b11);
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
